// File: rtl/pwm_duty_meter_if.sv
// Result bundle of the PWM duty meter.
// The meter drives it; slow-control logic consumes it.
interface pwm_duty_meter_if #(
    parameter int MXCNTBITS  = 16,
    parameter int MXDUTYBITS = 8
);
    logic [MXDUTYBITS-1:0] duty;
    logic [MXCNTBITS-1:0]  period;
    logic [MXCNTBITS-1:0]  high_time;
    logic                  valid;
    logic                  stuck;

    modport master (
        output duty, period, high_time, valid, stuck
    );

    modport slave (
        input duty, period, high_time, valid, stuck
    );
endinterface

// File: rtl/pwm_duty_meter.sv
// PWM duty/period meter.
// Sync, period/high counters, restoring divider, stuck flag.
module pwm_duty_meter #(
    parameter int MXCNTBITS  = 16,
    parameter int MXDUTYBITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pwm_in,
    pwm_duty_meter_if.master    meas
);
    localparam logic [MXCNTBITS-1:0] CNT_MAX = '1;
    localparam logic [MXCNTBITS-1:0] CNT_ONE = MXCNTBITS'(1);
    localparam int STEPW = $clog2(MXDUTYBITS);
    localparam logic [STEPW-1:0] STEP_LAST = STEPW'(MXDUTYBITS - 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t                 state;
    logic                   s1, s2, s3;
    logic                   rise;
    logic [MXCNTBITS-1:0]   per_cnt, hi_cnt;
    logic                   armed;
    logic [MXCNTBITS-1:0]   cap_per, cap_hi;
    logic [MXCNTBITS:0]     rem, rem_sh, rem_nx;
    logic                   qbit;
    logic [MXDUTYBITS-1:0]  quot, quot_nx;
    logic [STEPW-1:0]       step;
    logic                   sat;

    assign rise = s2 & ~s3;

    // Synchronise pwm_in and count period / high-time since last rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
            if (rise) begin
                per_cnt <= CNT_ONE;
                hi_cnt  <= CNT_ONE;
            end else begin
                if (per_cnt != CNT_MAX)
                    per_cnt <= per_cnt + 1'b1;
                if (s2 && hi_cnt != CNT_MAX)
                    hi_cnt <= hi_cnt + 1'b1;
            end
        end
    end

    // One restoring-division step: shift, trial subtract, quotient bit.
    always_comb begin
        rem_sh  = {rem[MXCNTBITS-1:0], 1'b0};
        qbit    = (rem_sh >= {1'b0, cap_per});
        rem_nx  = qbit ? (rem_sh - {1'b0, cap_per}) : rem_sh;
        quot_nx = {quot[MXDUTYBITS-2:0], qbit};
        sat     = (cap_hi >= cap_per);
    end

    // Capture, divide and publish results; outputs land on the edge
    // that enters DONE so valid and data appear together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            armed          <= 1'b0;
            cap_per        <= '0;
            cap_hi         <= '0;
            rem            <= '0;
            quot           <= '0;
            step           <= '0;
            meas.duty      <= '0;
            meas.period    <= '0;
            meas.high_time <= '0;
            meas.valid     <= 1'b0;
            meas.stuck     <= 1'b0;
        end else begin
            meas.valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (per_cnt == CNT_MAX && !meas.stuck) begin
                        meas.stuck     <= 1'b1;
                        meas.duty      <= s2 ? '1 : '0;
                        meas.period    <= '0;
                        meas.high_time <= '0;
                        meas.valid     <= 1'b1;
                        armed          <= 1'b0;
                    end else if (rise) begin
                        if (!armed) begin
                            armed <= 1'b1;
                        end else begin
                            cap_per <= per_cnt;
                            cap_hi  <= hi_cnt;
                            rem     <= {1'b0, hi_cnt};
                            quot    <= '0;
                            step    <= '0;
                            state   <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem  <= rem_nx;
                    quot <= quot_nx;
                    step <= step + 1'b1;
                    if (step == STEP_LAST) begin
                        meas.duty      <= sat ? '1 : quot_nx;
                        meas.period    <= cap_per;
                        meas.high_time <= cap_hi;
                        meas.stuck     <= 1'b0;
                        meas.valid     <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter.
// MXCNTBITS=8 so the stuck timeout stays short.
module tb_pwm_duty_meter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   v_cnt = 0;
    int   last_vcyc = 0;
    int   prev_vcyc = 0;
    int   rise_drv = 0;

    pwm_duty_meter_if #(.MXCNTBITS(8), .MXDUTYBITS(8)) bus ();

    pwm_duty_meter #(.MXCNTBITS(8), .MXDUTYBITS(8)) dut (
        .clock (clk),
        .reset (rst),
        .pwm_in(pwm),
        .meas  (bus)
    );

    always #5 clk = ~clk;

    // Edge counter; value during a cycle = edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Valid pulse logger, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (bus.valid === 1'b1) begin
            v_cnt     = v_cnt + 1;
            prev_vcyc = last_vcyc;
            last_vcyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_period(input int per, input int hi);
        pwm = 1'b1;
        rise_drv = cyc;
        tick(hi);
        pwm = 1'b0;
        tick(per - hi);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        pwm = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pwm = 1'b0;
        tick(4);
        n_cmp++;
        if (bus.duty !== 8'h00) begin
            n_bad++; $display("FAIL rst_duty got %0h exp 0", bus.duty);
        end
        n_cmp++;
        if (bus.period !== 8'd0) begin
            n_bad++; $display("FAIL rst_period got %0d exp 0", bus.period);
        end
        n_cmp++;
        if (bus.high_time !== 8'd0) begin
            n_bad++; $display("FAIL rst_high got %0d exp 0", bus.high_time);
        end
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_valid got %b exp 0", bus.valid);
        end
        n_cmp++;
        if (bus.stuck !== 1'b0) begin
            n_bad++; $display("FAIL rst_stuck got %b exp 0", bus.stuck);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        int n0;
        apply_reset();
        n0 = v_cnt;
        do_period(16, 4);
        n_cmp++;
        if (v_cnt !== n0) begin
            n_bad++; $display("FAIL first_rise got %0d exp %0d", v_cnt, n0);
        end
        for (int k = 1; k <= 2; k++) begin
            do_period(16, 4);
            n_cmp++;
            if (v_cnt !== n0 + k) begin
                n_bad++;
                $display("FAIL basic_cnt got %0d exp %0d", v_cnt, n0 + k);
            end
            n_cmp++;
            if (last_vcyc !== rise_drv + 11) begin
                n_bad++;
                $display("FAIL basic_lat got %0d exp %0d",
                         last_vcyc, rise_drv + 11);
            end
            n_cmp++;
            if (bus.duty !== 8'h40) begin
                n_bad++; $display("FAIL basic_duty got %0h exp 40", bus.duty);
            end
            n_cmp++;
            if (bus.period !== 8'd16) begin
                n_bad++; $display("FAIL basic_per got %0d exp 16", bus.period);
            end
            n_cmp++;
            if (bus.high_time !== 8'd4) begin
                n_bad++;
                $display("FAIL basic_hi got %0d exp 4", bus.high_time);
            end
        end
    endtask

    task automatic test_duty85();
        int n0;
        apply_reset();
        n0 = v_cnt;
        repeat (3) do_period(12, 4);
        n_cmp++;
        if (v_cnt !== n0 + 2) begin
            n_bad++; $display("FAIL d85_cnt got %0d exp %0d", v_cnt, n0 + 2);
        end
        n_cmp++;
        if (bus.duty !== 8'd85) begin
            n_bad++; $display("FAIL d85_duty got %0d exp 85", bus.duty);
        end
        n_cmp++;
        if (bus.period !== 8'd12) begin
            n_bad++; $display("FAIL d85_per got %0d exp 12", bus.period);
        end
        n_cmp++;
        if (bus.high_time !== 8'd4) begin
            n_bad++; $display("FAIL d85_hi got %0d exp 4", bus.high_time);
        end
        n_cmp++;
        if (bus.stuck !== 1'b0) begin
            n_bad++; $display("FAIL d85_stuck got %b exp 0", bus.stuck);
        end
    endtask

    task automatic test_stuck(input logic lvl);
        int  c;
        int  n;
        bit  found;
        apply_reset();
        repeat (3) do_period(16, 4);
        c = rise_drv;
        if (lvl) begin
            pwm = 1'b1;
            c = cyc;
        end
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1 && bus.stuck === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL stuck_seen lvl %b got none exp pulse", lvl);
        end
        n_cmp++;
        if (cyc < c + 250 || cyc > c + 262) begin
            n_bad++;
            $display("FAIL stuck_lat got %0d exp about %0d", cyc, c + 258);
        end
        n_cmp++;
        if (bus.duty !== (lvl ? 8'hFF : 8'h00)) begin
            n_bad++; $display("FAIL stuck_duty got %0h lvl %b", bus.duty, lvl);
        end
        n_cmp++;
        if (bus.period !== 8'd0 || bus.high_time !== 8'd0) begin
            n_bad++;
            $display("FAIL stuck_ph got %0d/%0d exp 0/0",
                     bus.period, bus.high_time);
        end
        tick(1);
        n = v_cnt;
        tick(100);
        n_cmp++;
        if (v_cnt !== n || bus.stuck !== 1'b1) begin
            n_bad++;
            $display("FAIL stuck_once got cnt %0d stuck %b exp cnt %0d stuck 1",
                     v_cnt, bus.stuck, n);
        end
    endtask

    task automatic test_recovery();
        int n0;
        pwm = 1'b0;
        tick(8);
        n0 = v_cnt;
        do_period(16, 4);
        n_cmp++;
        if (v_cnt !== n0) begin
            n_bad++; $display("FAIL rec_arm got %0d exp %0d", v_cnt, n0);
        end
        do_period(16, 4);
        n_cmp++;
        if (v_cnt !== n0 + 1) begin
            n_bad++; $display("FAIL rec_cnt got %0d exp %0d", v_cnt, n0 + 1);
        end
        n_cmp++;
        if (bus.duty !== 8'h40 || bus.stuck !== 1'b0) begin
            n_bad++;
            $display("FAIL rec_res got duty %0h stuck %b exp 40 0",
                     bus.duty, bus.stuck);
        end
        n_cmp++;
        if (bus.period !== 8'd16 || bus.high_time !== 8'd4) begin
            n_bad++;
            $display("FAIL rec_ph got %0d/%0d exp 16/4",
                     bus.period, bus.high_time);
        end
    endtask

    task automatic test_short();
        int n0;
        apply_reset();
        n0 = v_cnt;
        repeat (9) do_period(5, 2);
        tick(12);
        n_cmp++;
        if (v_cnt !== n0 + 4) begin
            n_bad++; $display("FAIL short_cnt got %0d exp %0d", v_cnt, n0 + 4);
        end
        n_cmp++;
        if (last_vcyc - prev_vcyc !== 10) begin
            n_bad++;
            $display("FAIL short_gap got %0d exp 10", last_vcyc - prev_vcyc);
        end
        n_cmp++;
        if (bus.duty !== 8'd102) begin
            n_bad++; $display("FAIL short_duty got %0d exp 102", bus.duty);
        end
        n_cmp++;
        if (bus.period !== 8'd5 || bus.high_time !== 8'd2) begin
            n_bad++;
            $display("FAIL short_ph got %0d/%0d exp 5/2",
                     bus.period, bus.high_time);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        repeat (2) do_period(16, 4);
        pwm = 1'b1;
        n = v_cnt;
        tick(4);
        pwm = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(20);
        n_cmp++;
        if (v_cnt !== n) begin
            n_bad++; $display("FAIL mid_novalid got %0d exp %0d", v_cnt, n);
        end
        n_cmp++;
        if (bus.duty !== 8'h00 || bus.period !== 8'd0 ||
            bus.high_time !== 8'd0 || bus.stuck !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_zero got %0h/%0d/%0d/%b exp 0/0/0/0",
                     bus.duty, bus.period, bus.high_time, bus.stuck);
        end
        do_period(16, 4);
        n_cmp++;
        if (v_cnt !== n) begin
            n_bad++; $display("FAIL mid_arm got %0d exp %0d", v_cnt, n);
        end
        do_period(16, 4);
        n_cmp++;
        if (v_cnt !== n + 1 || bus.duty !== 8'h40) begin
            n_bad++;
            $display("FAIL mid_resume got cnt %0d duty %0h exp %0d 40",
                     v_cnt, bus.duty, n + 1);
        end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_basic();
        test_duty85();
        test_stuck(1'b1);
        test_recovery();
        test_stuck(1'b0);
        test_short();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
